// File: rtl/frame_sync_if.sv
// Serial sync-path bundle between the bit source and the frame-alignment controller.
// The source (master) drives the bit, its qualifier and the hunt request. The controller (slave) returns the alignment status.
interface frame_sync_if #(
  parameter int CW = 5
);
  logic          s_in;
  logic          s_vld;
  logic          force_hunt;
  logic [1:0]    state;
  logic          locked;
  logic          frame_start;
  logic          sync_loss;
  logic [CW-1:0] bit_cnt;

  modport master (
    output s_in, s_vld, force_hunt,
    input  state, locked, frame_start, sync_loss, bit_cnt
  );

  modport slave (
    input  s_in, s_vld, force_hunt,
    output state, locked, frame_start, sync_loss, bit_cnt
  );
endinterface

// File: rtl/frame_sync_ctrl.sv
// Frame-alignment controller: hunts for SYNC_WORD, confirms it over CONFIRM frame
// boundaries, then holds lock until MISS_MAX consecutive sync words are missed.
module frame_sync_ctrl #(
  parameter int           N         = 5,
  parameter logic [N-1:0] SYNC_WORD = 5'b10100,
  parameter int           FRAME_LEN = 32,
  parameter int           CONFIRM   = 2,
  parameter int           MISS_MAX  = 3
) (
  input  logic        clk,
  input  logic        rst,
  frame_sync_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(CONFIRM + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  typedef enum logic [1:0] {
    HUNT     = 2'b00,
    PRESYNC  = 2'b01,
    SYNC     = 2'b10,
    FLYWHEEL = 2'b11
  } state_t;

  state_t        state_q, state_n;
  logic [N-2:0]  sr_q, sr_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [HW-1:0] hit_q, hit_n;
  logic [MW-1:0] miss_q, miss_n;
  logic          fs_q, fs_n;
  logic          sl_q, sl_n;
  logic          lock_q;
  logic [N-1:0]  win;
  logic          hit;
  logic          boundary;

  // Only the N-1 newest bits need storing; the current bit completes the window.
  assign win      = {sr_q, bus.s_in};
  assign hit      = (win == SYNC_WORD);
  assign boundary = (cnt_q == CW'(FRAME_LEN - 1));

  always_comb begin
    state_n = state_q;
    sr_n    = sr_q;
    cnt_n   = cnt_q;
    hit_n   = hit_q;
    miss_n  = miss_q;
    fs_n    = 1'b0;
    sl_n    = 1'b0;
    if (bus.force_hunt) begin
      state_n = HUNT;
      cnt_n   = '0;
      hit_n   = '0;
      miss_n  = '0;
    end else if (bus.s_vld) begin
      sr_n = win[N-2:0];
      if (state_q != HUNT)
        cnt_n = boundary ? '0 : cnt_q + CW'(1);
      case (state_q)
        HUNT: begin
          if (hit) begin
            state_n = PRESYNC;
            cnt_n   = '0;
            hit_n   = '0;
          end
        end
        PRESYNC: begin
          if (boundary) begin
            if (!hit) begin
              state_n = HUNT;
              cnt_n   = '0;
            end else if (hit_q + HW'(1) == HW'(CONFIRM)) begin
              state_n = SYNC;
              miss_n  = '0;
              fs_n    = 1'b1;
            end else begin
              hit_n = hit_q + HW'(1);
            end
          end
        end
        SYNC: begin
          if (boundary) begin
            if (hit) begin
              miss_n = '0;
              fs_n   = 1'b1;
            end else if (MISS_MAX == 1) begin
              state_n = HUNT;
              miss_n  = '0;
              sl_n    = 1'b1;
            end else begin
              state_n = FLYWHEEL;
              miss_n  = MW'(1);
              fs_n    = 1'b1;
            end
          end
        end
        FLYWHEEL: begin
          if (boundary) begin
            if (hit) begin
              state_n = SYNC;
              miss_n  = '0;
              fs_n    = 1'b1;
            end else if (miss_q + MW'(1) == MW'(MISS_MAX)) begin
              // Loss of lock: the boundary that drops us is not announced downstream.
              state_n = HUNT;
              miss_n  = '0;
              sl_n    = 1'b1;
            end else begin
              miss_n = miss_q + MW'(1);
              fs_n   = 1'b1;
            end
          end
        end
        default: begin
          state_n = HUNT;
          cnt_n   = '0;
          hit_n   = '0;
          miss_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sr_q    <= '0;
      cnt_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      fs_q    <= 1'b0;
      sl_q    <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      sr_q    <= sr_n;
      cnt_q   <= cnt_n;
      hit_q   <= hit_n;
      miss_q  <= miss_n;
      fs_q    <= fs_n;
      sl_q    <= sl_n;
      lock_q  <= (state_n == SYNC) || (state_n == FLYWHEEL);
    end
  end

  assign bus.state       = state_q;
  assign bus.locked      = lock_q;
  assign bus.frame_start = fs_q;
  assign bus.sync_loss   = sl_q;
  assign bus.bit_cnt     = cnt_q;
endmodule
